// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and DRAM-side signals of the shared memory port.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_port_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_timeout;

  modport slave (
    input  instr_req, instr_addr, data_req, data_addr, data_we, data_be, data_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output instr_gnt, instr_rvalid, instr_rdata, data_gnt, data_rvalid, data_rdata,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata, err_timeout
  );

  modport master (
    output instr_req, instr_addr, data_req, data_addr, data_we, data_be, data_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  instr_gnt, instr_rvalid, instr_rdata, data_gnt, data_rvalid, data_rdata,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one DRAM port between instruction fetch and load/store; data has priority
// bounded by a streak limit, one outstanding transaction, response timeout with sticky error.
module mem_port_arbiter #(
  parameter int          MAX_DATA_STREAK = 4,
  parameter int          TIMEOUT_CYCLES  = 64,
  parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
  input logic           clock,
  input logic           reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Abort lands TIMEOUT_CYCLES cycles after the grant cycle.
  localparam int ABORT_AT = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] ABORT_CNT  = TW'(ABORT_AT);

  state_t        state, nxt;
  logic          owner_data;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic [31:0]   addr_q, wdata_q, rd_i, rd_d;
  logic [3:0]    be_q;
  logic          we_q, rv_i, rv_d, err_q;

  logic data_wins, launch, gnt_hit, rsp, tmo;

  assign data_wins = bus.data_req && (!bus.instr_req || (streak < STREAK_MAX));
  assign launch    = (state == IDLE) && (bus.data_req || bus.instr_req);
  assign gnt_hit   = (state == REQ) && bus.mem_gnt;
  assign rsp       = (state == WAIT_RSP) && bus.mem_rvalid;
  assign tmo       = (state == WAIT_RSP) && !bus.mem_rvalid && (tcnt == ABORT_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (launch) nxt = REQ;
      REQ:      if (bus.mem_gnt) nxt = WAIT_RSP;
      WAIT_RSP: if (rsp || tmo) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_data <= 1'b0;
      streak     <= '0;
      tcnt       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rv_i       <= 1'b0;
      rv_d       <= 1'b0;
      rd_i       <= '0;
      rd_d       <= '0;
      err_q      <= 1'b0;
    end else begin
      rv_i <= 1'b0;
      rv_d <= 1'b0;
      if (launch) begin
        owner_data <= data_wins;
        if (data_wins) begin
          addr_q  <= bus.data_addr;
          we_q    <= bus.data_we;
          be_q    <= bus.data_be;
          wdata_q <= bus.data_wdata;
          if (!bus.instr_req)           streak <= '0;
          else if (streak != STREAK_MAX) streak <= streak + 1'b1;
        end else begin
          addr_q  <= bus.instr_addr;
          we_q    <= 1'b0;
          be_q    <= 4'hF;
          wdata_q <= '0;
          streak  <= '0;
        end
      end
      if (gnt_hit)
        tcnt <= '0;
      else if ((state == WAIT_RSP) && !bus.mem_rvalid && !tmo)
        tcnt <= tcnt + 1'b1;
      if (rsp || tmo) begin
        if (owner_data) begin
          rv_d <= 1'b1;
          rd_d <= rsp ? bus.mem_rdata : ERR_RDATA;
        end else begin
          rv_i <= 1'b1;
          rd_i <= rsp ? bus.mem_rdata : ERR_RDATA;
        end
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_req      = (state == REQ);
    bus.mem_addr     = addr_q;
    bus.mem_we       = we_q;
    bus.mem_be       = be_q;
    bus.mem_wdata    = wdata_q;
    bus.instr_gnt    = gnt_hit && !owner_data;
    bus.data_gnt     = gnt_hit && owner_data;
    bus.instr_rvalid = rv_i;
    bus.data_rvalid  = rv_d;
    bus.instr_rdata  = rd_i;
    bus.data_rdata   = rd_d;
    bus.err_timeout  = err_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single DRAM port between instruction fetch and load/store data accesses of the core.
- Registers the winning request and drives it on the memory port until grant, then waits for the response and routes it back to the owner.
- Gives data priority, with a streak limit so fetch cannot starve, and a response timeout with a sticky error flag.

Parameters:
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while instr_req is pending before instruction is forced to win (must be ≥1).
- TIMEOUT_CYCLES, 64, number of cycles in WAIT_RSP without mem_rvalid before the transaction is aborted (must be ≥1).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- instr_req  in  1  fetch request; held with instr_addr until instr_gnt.
- instr_addr  in  32  fetch address.
- instr_gnt  out  1  one-cycle pulse: fetch accepted by memory.
- instr_rvalid  out  1  one-cycle pulse: instr_rdata valid.
- instr_rdata  out  32  fetched instruction.
- data_req  in  1  load/store request; held with its fields until data_gnt.
- data_addr  in  32  data address.
- data_we  in  1  1 = store, 0 = load.
- data_be  in  4  byte enables.
- data_wdata  in  32  store data.
- data_gnt  out  1  one-cycle pulse: data access accepted.
- data_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
- data_rdata  out  32  load data.
- mem_req  out  1  request valid to DRAM.
- mem_addr  out  32  address to DRAM.
- mem_we  out  1  write enable to DRAM.
- mem_be  out  4  byte enables to DRAM.
- mem_wdata  out  32  write data to DRAM.
- mem_gnt  in  1  DRAM accepts the request this cycle.
- mem_rvalid  in  1  DRAM response (read data or write ack).
- mem_rdata  in  32  DRAM read data.
- err_timeout  out  1  sticky; set on any response timeout.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; streak and timeout counters are cleared; owner = INSTR.
  - All outputs are 0 and mem_* buses are 0; err_timeout is cleared only by reset.
- FSM states are IDLE, REQ and WAIT_RSP.
- IDLE, arbitration:
  - If data_req and (not instr_req or streak < MAX_DATA_STREAK), data wins. Else if instr_req, instr wins. Else stay in IDLE.
  - The winner's address and control fields are latched into mem_* registers and the owner is recorded. Next state is REQ; mem_req = 1 from the next cycle.
  - Fetches drive mem_we = 0, mem_be = 4'hF and mem_wdata = 0.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) when data wins while instr_req = 1.
  - Clears when instr wins or when data wins with instr_req = 0.
- REQ:
  - mem_req and mem_* are held stable until mem_gnt = 1.
  - On the mem_gnt cycle: the owner's *_gnt is pulsed in the same cycle (combinational from mem_gnt and state), mem_req drops next cycle, the timeout counter clears, and next state is WAIT_RSP.
  - Requester inputs are not re-sampled in REQ.
- WAIT_RSP:
  - On mem_rvalid: mem_rdata is registered into the owner's *_rdata, and the owner's *_rvalid pulses the next cycle. Next state is IDLE.
  - Otherwise the counter increments. When the count reaches TIMEOUT_CYCLES-1 with no rvalid: err_timeout is set, the owner's *_rvalid pulses next cycle with rdata = ERR_RDATA, and next state is IDLE.
  - mem_rvalid in any other state is ignored.
  - The non-owner's rdata keeps its last value.
- Minimum latency (mem_gnt same cycle, rvalid one cycle later):
  - req sampled in IDLE at cycle N.
  - mem_req and gnt at N+1.
  - mem_rvalid at N+2.
  - *_rvalid at N+3.
  - Next arbitration at N+3; the block is non-pipelined, with one outstanding transaction.
- Requesters must deassert req in the cycle after gnt unless they issue a new access. A req still high in IDLE is treated as a new request.
- Reset mid-transaction abandons it: no gnt or rvalid is issued afterwards, and the memory-side response is dropped.

Test Plan:
- Single fetch:
  - Stimulus: instr_req with instr_addr=0x10; mem_gnt at first mem_req cycle; mem_rvalid one cycle later with 0x00500093.
  - Required: mem_addr=0x10, mem_we=0; instr_gnt at N+1; instr_rvalid at N+3 with instr_rdata=0x00500093; data_* stay 0.
- Store:
  - Stimulus: data_req, data_we=1, addr=0x80, be=4'b0011, wdata=0x1234; mem_gnt delayed 3 cycles.
  - Required: mem_* held stable for 4 cycles; data_gnt only on the mem_gnt cycle; data_rvalid one cycle after mem_rvalid.
- Simultaneous requests with MAX_DATA_STREAK=4:
  - Stimulus: instr_req and data_req both held high with continuous accesses.
  - Required: grant order is D,D,D,D,I,D,D,D,D,I.
- Timeout with TIMEOUT_CYCLES=8:
  - Stimulus: load granted, mem_rvalid never asserted.
  - Required: err_timeout rises 8 cycles after mem_gnt; data_rvalid pulses once with 0xDEADBEEF; the next instr_req is served normally; err_timeout stays 1.
- Async reset mid-transaction:
  - Stimulus: reset low during WAIT_RSP, asynchronously and not clock-aligned.
  - Required: all outputs go to 0 immediately; a mem_rvalid arriving after reset release is ignored; a fresh fetch completes normally.
